// File: rtl/cordic_phase_front_if.sv
// Control and sample bus between the NCO front end and its controller / first rotator stage.
// Latency: none (wires only).
// Backpressure: none; the sample side is a fire-and-forget valid pulse.
interface cordic_phase_front_if #(
    parameter int ACC_W = 32
);
    // Controller -> front end
    logic             start;
    logic             stop;
    logic [ACC_W-1:0] freq_in;
    logic             freq_wr;
    logic [15:0]      phase_ofs;
    logic [7:0]       rate_div;

    // Front end -> first rotator stage / controller
    logic signed [13:0] X_out;
    logic signed [13:0] Y_out;
    logic signed [15:0] Z_out;
    logic [1:0]         quart_out;
    logic               valid_out;
    logic               busy;

    // Controller side: drives configuration, observes samples
    modport master (
        output start, stop, freq_in, freq_wr, phase_ofs, rate_div,
        input  X_out, Y_out, Z_out, quart_out, valid_out, busy
    );

    // Front-end side: consumes configuration, produces samples
    modport slave (
        input  start, stop, freq_in, freq_wr, phase_ofs, rate_div,
        output X_out, Y_out, Z_out, quart_out, valid_out, busy
    );
endinterface

// File: rtl/cordic_phase_front.sv
// Rate-controlled phase accumulator; folds each phase sample into quadrant + first-quadrant residual.
// Latency: one clock from tick to registered sample (valid_out pulse).
// Backpressure: none; the downstream rotator pipeline must accept one sample per valid_out pulse.
module cordic_phase_front #(
    parameter int          ACC_W  = 32,
    parameter logic [13:0] X_INIT = 14'd4974
) (
    input  logic                  clk,
    input  logic                  reset,
    cordic_phase_front_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 16-bit phase sample: top two bits select the quadrant, the rest is the residual angle
    typedef struct packed {
        logic [1:0]  quart;
        logic [13:0] resid;
    } phase_smp_t;

    state_t             state_q,  state_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [ACC_W-1:0]   step_q,   step_d;
    logic [7:0]         divcnt_q, divcnt_d;
    logic [7:0]         rate_q,   rate_d;
    logic signed [13:0] x_q,      x_d;
    logic signed [13:0] y_q,      y_d;
    logic signed [15:0] z_q,      z_d;
    logic [1:0]         quart_q,  quart_d;
    logic               valid_q,  valid_d;

    logic               tick;
    phase_smp_t         smp;

    // Tick at the end of each sample period; a stop in the same cycle suppresses it
    assign tick = (state_q == RUN) && (divcnt_q == rate_q) && !bus.stop;

    // Sample uses the accumulator value before this tick's increment
    assign smp = phase_smp_t'(acc_q[ACC_W-1 -: 16] + bus.phase_ofs);

    // Next-state logic for control FSM, accumulator, divider and output sample registers
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        step_d   = step_q;
        divcnt_d = divcnt_q;
        rate_d   = rate_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        quart_d  = quart_q;
        valid_d  = 1'b0;

        // Step register can be reloaded at any time; a coincident tick still adds the old step
        if (bus.freq_wr) begin
            step_d = bus.freq_in;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    divcnt_d = '0;
                    rate_d   = bus.rate_div;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    divcnt_d = '0;
                    acc_d    = acc_q + step_q;
                    quart_d  = smp.quart;
                    z_d      = {2'b00, smp.resid};
                    x_d      = X_INIT;
                    y_d      = '0;
                    valid_d  = 1'b1;
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            step_q   <= '0;
            divcnt_q <= '0;
            rate_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            quart_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            divcnt_q <= divcnt_d;
            rate_q   <= rate_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            quart_q  <= quart_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.X_out     = x_q;
    assign bus.Y_out     = y_q;
    assign bus.Z_out     = z_q;
    assign bus.quart_out = quart_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state_q == RUN);

endmodule
